// File: rtl/la_iopad_ctrl_if.sv
// Register-port interface for la_iopad_ctrl: request channel from core, response back.
// A request transfers on a clock edge where req_valid && req_ready; a response transfers
// on an edge where rsp_valid && rsp_ready. The slave holds rsp_* stable while rsp_valid waits.
interface la_iopad_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/la_iopad_ctrl.sv
// Pad-ring control: shadow/active per-pin tech cfg and output overrides loaded over a
// register port and committed atomically, plus a gated 2-flop synchroniser for pad inputs.
module la_iopad_ctrl #(
  parameter int              NSIDES = 4,
  parameter int              NPINS  = 9,
  parameter int              CFGW   = 18,
  parameter int              AW     = 8,
  parameter int              DW     = 32,
  parameter logic [CFGW-1:0] CFGRST = '0,
  localparam int             N      = NSIDES * NPINS
) (
  input  logic                clk,
  input  logic                reset,
  la_iopad_ctrl_if.slave      bus,
  input  logic [N-1:0]        core_dout,
  input  logic [N-1:0]        core_oen,
  input  logic [N-1:0]        core_ie,
  output logic [N-1:0]        core_din,
  output logic [N-1:0]        pad_a,
  output logic [N-1:0]        pad_oe,
  output logic [N-1:0]        pad_ie,
  output logic [N*CFGW-1:0]   pad_cfg,
  input  logic [N-1:0]        pad_zp,
  output logic                fsm_state
);

  localparam int          NDIN   = (N + DW - 1) / DW;
  localparam logic [31:0] A_CTRL = 32'(N);
  localparam logic [31:0] A_STAT = 32'(N + 1);
  localparam logic [31:0] A_DIN  = 32'(N + 2);
  localparam logic [31:0] A_END  = 32'(N + 2 + NDIN);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t state_q, state_d;

  // Override nibble per pin: [0] en, [1] a, [2] oe, [3] ie.
  logic [N-1:0][CFGW-1:0] sh_cfg, act_cfg;
  logic [N-1:0][3:0]      sh_ovr, act_ovr;
  logic                   pending, autocommit, commit_req;

  logic [DW-1:0]          rsp_rdata_q;
  logic                   rsp_err_q;
  logic [N-1:0]           sync1, sync2;

  logic                   accept;
  logic [31:0]            addr;
  logic                   is_pin, is_ctrl, is_stat, is_din, dec_err;
  logic [DW-1:0]          rd_data;
  logic [NDIN*DW-1:0]     din_flat;
  logic [N-1:0]           ovr_en, ovr_a, ovr_oe, ovr_ie;
  logic                   unused_wdata;

  assign addr         = 32'(bus.req_addr);
  assign accept       = (state_q == IDLE) && bus.req_valid;
  assign unused_wdata = ^bus.req_wdata;

  // Handshake FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Handshake FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake FSM: outputs
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE:    bus.req_ready = 1'b1;
      RESP:    bus.rsp_valid = 1'b1;
      default: bus.req_ready = 1'b1;
    endcase
  end

  assign fsm_state     = state_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // Address decode and read mux
  always_comb begin
    is_pin   = (addr < A_CTRL);
    is_ctrl  = (addr == A_CTRL);
    is_stat  = (addr == A_STAT);
    is_din   = (addr >= A_DIN) && (addr < A_END);
    dec_err  = !(is_pin || is_ctrl || is_stat || is_din);
    din_flat = '0;
    din_flat[N-1:0] = core_din;
    rd_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (addr == 32'(i)) rd_data[CFGW+3:0] = {sh_ovr[i], sh_cfg[i]};
    end
    if (is_ctrl) rd_data[1] = autocommit;
    if (is_stat) rd_data[0] = pending;
    for (int k = 0; k < NDIN; k++) begin
      if (addr == 32'(N + 2 + k)) rd_data = din_flat[k*DW +: DW];
    end
  end

  // Register file, commit and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        sh_cfg[i]  <= CFGRST;
        act_cfg[i] <= CFGRST;
      end
      sh_ovr      <= '0;
      act_ovr     <= '0;
      pending     <= 1'b0;
      autocommit  <= 1'b0;
      commit_req  <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      commit_req <= 1'b0;
      if (commit_req) begin
        act_cfg <= sh_cfg;
        act_ovr <= sh_ovr;
        pending <= 1'b0;
      end
      if (accept) begin
        rsp_rdata_q <= bus.req_write ? '0 : rd_data;
        rsp_err_q   <= dec_err;
        if (bus.req_write) begin
          for (int i = 0; i < N; i++) begin
            if (addr == 32'(i)) begin
              sh_cfg[i] <= bus.req_wdata[CFGW-1:0];
              sh_ovr[i] <= bus.req_wdata[CFGW+3:CFGW];
            end
          end
          if (is_pin) begin
            pending <= 1'b1;
            if (autocommit) commit_req <= 1'b1;
          end
          if (is_ctrl) begin
            autocommit <= bus.req_wdata[1];
            commit_req <= bus.req_wdata[0];
          end
        end
      end
    end
  end

  // Pad input synchroniser; gating happens after the second flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pad_zp;
      sync2 <= sync1;
    end
  end

  always_comb begin
    ovr_en = '0;
    ovr_a  = '0;
    ovr_oe = '0;
    ovr_ie = '0;
    for (int i = 0; i < N; i++) begin
      ovr_en[i] = act_ovr[i][0];
      ovr_a[i]  = act_ovr[i][1];
      ovr_oe[i] = act_ovr[i][2];
      ovr_ie[i] = act_ovr[i][3];
    end
  end

  assign pad_a    = (ovr_en & ovr_a)  | (~ovr_en & core_dout);
  assign pad_oe   = (ovr_en & ovr_oe) | (~ovr_en & ~core_oen);
  assign pad_ie   = (ovr_en & ovr_ie) | (~ovr_en & core_ie);
  assign pad_cfg  = act_cfg;
  assign core_din = sync2 & pad_ie;

endmodule

// File: tb/tb_la_iopad_ctrl.sv
// Directed plus randomized bench for la_iopad_ctrl against a register-level model.
module tb_la_iopad_ctrl;
  localparam int              NSIDES = 4;
  localparam int              NPINS  = 9;
  localparam int              CFGW   = 18;
  localparam int              AW     = 8;
  localparam int              DW     = 32;
  localparam int              N      = NSIDES * NPINS;
  localparam int              NDIN   = (N + DW - 1) / DW;
  localparam logic [CFGW-1:0] CFGRST = 18'h2A5C3;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  la_iopad_ctrl_if #(.AW(AW), .DW(DW)) bus ();
  logic [N-1:0]      core_dout, core_oen, core_ie, core_din;
  logic [N-1:0]      pad_a, pad_oe, pad_ie, pad_zp;
  logic [N*CFGW-1:0] pad_cfg;
  logic              fsm_state;

  la_iopad_ctrl #(
    .NSIDES(NSIDES), .NPINS(NPINS), .CFGW(CFGW), .AW(AW), .DW(DW), .CFGRST(CFGRST)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .core_dout(core_dout), .core_oen(core_oen), .core_ie(core_ie), .core_din(core_din),
    .pad_a(pad_a), .pad_oe(pad_oe), .pad_ie(pad_ie), .pad_cfg(pad_cfg),
    .pad_zp(pad_zp), .fsm_state(fsm_state)
  );

  // reference model: register view of the block
  logic [CFGW-1:0] m_sh_cfg [N];
  logic [CFGW-1:0] m_act_cfg[N];
  logic [3:0]      m_sh_ovr [N];
  logic [3:0]      m_act_ovr[N];
  bit              m_pend, m_auto, m_commit_due;

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int            chk_cnt = 0;
  int            pass_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_sh_cfg[i] = CFGRST; m_act_cfg[i] = CFGRST;
      m_sh_ovr[i] = 4'h0;   m_act_ovr[i] = 4'h0;
    end
    m_pend = 0; m_auto = 0; m_commit_due = 0;
    exp_q.delete();
  endtask

  task automatic m_pads(output logic [N-1:0] ea, output logic [N-1:0] eo,
                        output logic [N-1:0] ei, output logic [N*CFGW-1:0] ec);
    for (int i = 0; i < N; i++) begin
      if (m_act_ovr[i][0]) begin
        ea[i] = m_act_ovr[i][1]; eo[i] = m_act_ovr[i][2]; ei[i] = m_act_ovr[i][3];
      end else begin
        ea[i] = core_dout[i]; eo[i] = ~core_oen[i]; ei[i] = core_ie[i];
      end
      ec[i*CFGW +: CFGW] = m_act_cfg[i];
    end
  endtask

  function automatic logic [DW-1:0] m_read(input int a, input logic [N-1:0] din);
    logic [NDIN*DW-1:0] p;
    logic [DW-1:0]      r;
    p = '0;
    p[N-1:0] = din;
    r = '0;
    if (a < N) r = DW'({m_sh_ovr[a], m_sh_cfg[a]});
    else if (a == N) r = DW'({m_auto, 1'b0});
    else if (a == N + 1) r = DW'(m_pend);
    else if (a < N + 2 + NDIN) r = p[(a - N - 2)*DW +: DW];
    return r;
  endfunction

  task automatic m_write(input bit w, input int a, input logic [DW-1:0] wd);
    if (!w) return;
    if (a < N) begin
      m_sh_cfg[a] = wd[CFGW-1:0];
      m_sh_ovr[a] = wd[CFGW+3:CFGW];
      m_pend = 1;
      if (m_auto) m_commit_due = 1;
    end else if (a == N) begin
      m_auto = wd[1];
      if (wd[0]) m_commit_due = 1;
    end
  endtask

  task automatic m_apply_commit();
    if (m_commit_due) begin
      for (int i = 0; i < N; i++) begin
        m_act_cfg[i] = m_sh_cfg[i]; m_act_ovr[i] = m_sh_ovr[i];
      end
      m_pend = 0; m_commit_due = 0;
    end
  endtask

  task automatic check_pads(input string tag);
    logic [N-1:0]      ea, eo, ei;
    logic [N*CFGW-1:0] ec;
    m_pads(ea, eo, ei, ec);
    check({tag, "_pad_a"},  64'(pad_a),  64'(ea));
    check({tag, "_pad_oe"}, 64'(pad_oe), 64'(eo));
    check({tag, "_pad_ie"}, 64'(pad_ie), 64'(ei));
    chk_cnt++;
    assert (pad_cfg === ec) pass_cnt++;
    else begin
      for (int i = 0; i < N; i++) begin
        if (pad_cfg[i*CFGW +: CFGW] !== ec[i*CFGW +: CFGW]) begin
          $error("FAIL %s_pad_cfg pin=%0d observed=%h expected=%h", tag, i,
                 pad_cfg[i*CFGW +: CFGW], ec[i*CFGW +: CFGW]);
          break;
        end
      end
    end
  endtask

  task automatic exp_din(output logic [N-1:0] d);
    logic [N-1:0]      ea, eo, ei;
    logic [N*CFGW-1:0] ec;
    m_pads(ea, eo, ei, ec);
    d = pad_zp & ei;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // driver: one full request/response, rsp_ready held low for 'hold' cycles
  task automatic do_txn(input bit w, input int a, input logic [DW-1:0] wd, input int hold);
    int            n;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    logic [N-1:0]  din_now;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    exp_din(din_now);
    exp_rd  = w ? '0 : m_read(a, din_now);
    exp_err = !(a < N + 2 + NDIN);
    exp_q.push_back(exp_rd);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = AW'(a); bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    m_write(w, a, wd);
    check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("req_ready_busy", 64'(bus.req_ready), 64'd0);
    check("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_q.pop_front()));
    check("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
    check_pads("pre_commit");
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      m_apply_commit();
      check("rsp_hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("rsp_hold_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    m_apply_commit();
    check("rsp_done_valid", 64'(bus.rsp_valid), 64'd0);
    check_pads("post_commit");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] d;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    core_dout = '0; core_oen = '1; core_ie = '1; pad_zp = '1;
    m_reset();
    idle(3);
    check("reset_core_din", 64'(core_din), 64'd0);
    check("reset_req_ready", 64'(bus.req_ready), 64'd1);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
    check("reset_fsm_state", 64'(fsm_state), 64'd0);
    check_pads("reset");
    reset = 1'b0; pad_zp = '0;
    idle(2);

    // shadow write is invisible on the pads until commit
    do_txn(1, 5, 32'h0_1234, 0);
    do_txn(0, 5, '0, 1);
    do_txn(0, N + 1, '0, 0);
    check("pin5_cfg_before_commit", 64'(pad_cfg[5*CFGW +: CFGW]), 64'(CFGRST));
    do_txn(1, N, 32'h1, 0);
    check("pin5_cfg_committed", 64'(pad_cfg[5*CFGW +: CFGW]), 64'h1234);
    do_txn(0, N + 1, '0, 0);

    // override on pin 0 beats the core's disabled output
    core_oen = '1; core_dout = '0;
    do_txn(1, 0, 32'(1 << CFGW) | 32'(1 << (CFGW + 1)) | 32'(1 << (CFGW + 2)) | 32'h55, 2);
    do_txn(1, N, 32'h1, 0);
    check("ovr_pad_oe0", 64'(pad_oe[0]), 64'd1);
    check("ovr_pad_a0", 64'(pad_a[0]), 64'd1);

    // unmapped address and read-only write
    do_txn(0, N + 7, '0, 0);
    do_txn(1, N + 7, 32'hFFFF_FFFF, 0);
    do_txn(1, N + 1, 32'hFFFF_FFFF, 0);
    do_txn(1, N + 2, 32'hFFFF_FFFF, 0);
    do_txn(0, 5, '0, 0);

    // synchroniser latency and input gating on pin 3
    core_ie[3] = 1'b1; pad_zp[3] = 1'b0;
    idle(3);
    pad_zp[3] = 1'b1;
    idle(1);
    check("sync_1edge", 64'(core_din[3]), 64'd0);
    idle(1);
    check("sync_2edge", 64'(core_din[3]), 64'd1);
    core_ie[3] = 1'b0;
    #1;
    check("sync_gated", 64'(core_din[3]), 64'd0);
    idle(3);
    check("sync_gated_hold", 64'(core_din[3]), 64'd0);

    // autocommit
    do_txn(1, N, 32'h2, 0);
    do_txn(0, N, '0, 0);
    do_txn(1, 7, 32'h3_ABCDE, 1);
    do_txn(0, N + 1, '0, 0);
    check("auto_pin7_cfg", 64'(pad_cfg[7*CFGW +: CFGW]), 64'h3ABCDE & 64'h3FFFF);
    do_txn(1, N, 32'h0, 0);

    // din readback
    core_ie = N'({$urandom, $urandom}); pad_zp = N'({$urandom, $urandom});
    idle(2);
    exp_din(d);
    check("din_direct", 64'(core_din), 64'(d));
    do_txn(0, N + 2, '0, 0);
    do_txn(0, N + 3, '0, 0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      int kind, a, hold;
      bit w;
      logic [DW-1:0] wd;
      core_dout = N'({$urandom, $urandom});
      core_oen  = N'({$urandom, $urandom});
      core_ie   = N'({$urandom, $urandom});
      pad_zp    = N'({$urandom, $urandom});
      idle(2);
      exp_din(d);
      check("rand_core_din", 64'(core_din), 64'(d));
      kind = $urandom_range(0, 6);
      wd = $urandom;
      hold = $urandom_range(0, 3);
      w = 0;
      case (kind)
        0, 1: begin w = 1; a = $urandom_range(0, N - 1); end
        2:    a = $urandom_range(0, N - 1);
        3:    begin w = 1; a = N; wd = 32'($urandom_range(0, 3)); end
        4:    a = $urandom_range(N, N + 1);
        5:    a = $urandom_range(N + 2, N + 1 + NDIN);
        default: begin w = 1'($urandom_range(0, 1)); a = $urandom_range(N + 2 + NDIN, 255); end
      endcase
      do_txn(w, a, wd, hold);
    end

    // reset while a response is stalled; reset also wins over a concurrent request
    do_txn(1, 1, 32'h1_1111, 0);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = AW'(5);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    idle(3);
    check("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    reset = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = AW'(2); bus.req_wdata = 32'h2_2222;
    @(posedge clk); #1;
    m_reset();
    check("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_mid_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_mid_rdata", 64'(bus.rsp_rdata), 64'd0);
    idle(1);
    reset = 1'b0; bus.req_valid = 1'b0;
    #1;
    check("rst_mid_idle_valid", 64'(bus.rsp_valid), 64'd0);
    check_pads("after_reset");
    do_txn(0, 1, '0, 0);
    do_txn(0, 2, '0, 0);
    do_txn(0, N + 1, '0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
